// File: rtl/multdiv_sequencer.sv
// ============================================================================
// multdiv_sequencer : iterative signed 32-bit Booth multiply / restoring divide
//                     driving an external shared ALU, one add/sub per cycle.
// Revision 1.0
// ============================================================================
`default_nettype none

module multdiv_sequencer #(
   parameter int ITER = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy,
   output logic [31:0] alu_operandA,
   output logic [31:0] alu_operandB,
   output logic [4:0]  alu_opcode,
   output logic [4:0]  alu_shamt,
   input  logic [31:0] alu_result
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_SUB = 5'd1;

   localparam int                CNT_W    = $clog2(ITER);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITER - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_q, div_d;
   logic             neg_q, neg_d;
   logic [31:0]      p_q, p_d;      // Booth P / divider remainder R
   logic [31:0]      q_q, q_d;      // Booth Q / divider quotient Qd
   logic             qm1_q, qm1_d;
   logic [31:0]      m_q, m_d;      // multiplicand M / divisor magnitude D
   logic [31:0]      result_q, result_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;

   logic        start;
   logic        start_div;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [1:0]  booth_bits;
   logic        booth_add;
   logic        booth_sub;
   logic [31:0] p_new;
   logic        p_ovf;
   logic        p_sign;
   logic [31:0] r_sh;
   logic        borrow;

   assign start      = ctrl_MULT | ctrl_DIV;
   assign start_div  = ctrl_DIV & ~ctrl_MULT;
   assign a_mag      = data_operandA[31] ? -data_operandA : data_operandA;
   assign b_mag      = data_operandB[31] ? -data_operandB : data_operandB;

   assign booth_bits = {q_q[0], qm1_q};
   assign booth_add  = (booth_bits == 2'b01);
   assign booth_sub  = (booth_bits == 2'b10);
   assign p_new      = (booth_add | booth_sub) ? alu_result : p_q;

   // P can transiently need a 33rd bit (e.g. M = -2^31); recover the true
   // sign from ALU overflow so the arithmetic shift stays exact.
   assign p_ovf  = (booth_add & (p_q[31] == m_q[31]) & (alu_result[31] != p_q[31])) |
                   (booth_sub & (p_q[31] != m_q[31]) & (alu_result[31] != p_q[31]));
   assign p_sign = p_new[31] ^ p_ovf;

   assign r_sh   = {p_q[30:0], q_q[31]};
   assign borrow = (~r_sh[31] & m_q[31]) |
                   (~(r_sh[31] ^ m_q[31]) & alu_result[31]);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         div_q    <= 1'b0;
         neg_q    <= 1'b0;
         p_q      <= '0;
         q_q      <= '0;
         qm1_q    <= 1'b0;
         m_q      <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         neg_q    <= neg_d;
         p_q      <= p_d;
         q_q      <= q_d;
         qm1_q    <= qm1_d;
         m_q      <= m_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      div_d    = div_q;
      neg_d    = neg_q;
      p_d      = p_q;
      q_d      = q_q;
      qm1_d    = qm1_q;
      m_d      = m_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;

      if (start) begin
         state_d = S_RUN;
         cnt_d   = '0;
         div_d   = start_div;
         p_d     = '0;
         qm1_d   = 1'b0;
         if (start_div) begin
            q_d   = a_mag;
            m_d   = b_mag;
            neg_d = data_operandA[31] ^ data_operandB[31];
         end else begin
            q_d   = data_operandB;
            m_d   = data_operandA;
            neg_d = 1'b0;
         end
      end else begin
         case (state_q)
            S_RUN: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_FIX;
               end
               if (div_q) begin
                  p_d = borrow ? r_sh : alu_result;
                  q_d = {q_q[30:0], ~borrow};
               end else begin
                  p_d   = {p_sign, p_new[31:1]};
                  q_d   = {p_new[0], q_q[31:1]};
                  qm1_d = q_q[0];
               end
            end
            S_FIX: begin
               state_d = S_IDLE;
               rdy_d   = 1'b1;
               if (div_q) begin
                  if (m_q == 32'd0) begin
                     result_d = 32'd0;
                     exc_d    = 1'b1;
                  end else begin
                     result_d = neg_q ? -q_q : q_q;
                     // A positive quotient of magnitude 2^31 only arises from -2^31 / -1.
                     exc_d    = q_q[31] & ~neg_q;
                  end
               end else begin
                  result_d = q_q;
                  exc_d    = ~((&{p_q, q_q[31]}) | ~(|{p_q, q_q[31]}));
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      alu_operandA = '0;
      alu_operandB = '0;
      alu_opcode   = OP_ADD;
      if (state_q == S_RUN) begin
         alu_operandB = m_q;
         if (div_q) begin
            alu_operandA = r_sh;
            alu_opcode   = OP_SUB;
         end else begin
            alu_operandA = p_q;
            alu_opcode   = booth_sub ? OP_SUB : OP_ADD;
         end
      end
   end

   assign alu_shamt      = 5'd0;
   assign busy           = (state_q != S_IDLE);
   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
// ============================================================================
// tb_multdiv_sequencer : randomized and directed checks against an arithmetic
//                        reference model; the shared ALU is modelled here.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;
   logic [31:0] alu_operandA;
   logic [31:0] alu_operandB;
   logic [4:0]  alu_opcode;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_result;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_hold = 32'd0;

   always #5 clock = ~clock;

   assign alu_result = (alu_opcode == 5'd1) ? alu_operandA - alu_operandB
                                            : alu_operandA + alu_operandB;

   multdiv_sequencer #(.ITER(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy),
      .alu_operandA   (alu_operandA),
      .alu_operandB   (alu_operandB),
      .alu_opcode     (alu_opcode),
      .alu_shamt      (alu_shamt),
      .alu_result     (alu_result)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // mode: 0 multiply, 1 divide, 2 both strobes (multiply takes precedence)
   task automatic ref_model(input int mode, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] er, output logic ee);
      longint      pa;
      longint      pb;
      longint      r;
      logic [63:0] rv;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      if (mode != 1) begin
         r  = pa * pb;
         rv = r;
         er = rv[31:0];
         ee = (r != longint'($signed(rv[31:0])));
      end else if (b == 32'd0) begin
         er = 32'd0;
         ee = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         er = 32'h8000_0000;
         ee = 1'b1;
      end else begin
         r  = pa / pb;
         rv = r;
         er = rv[31:0];
         ee = 1'b0;
      end
   endtask

   task automatic start_op(input int mode, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = (mode != 1);
      ctrl_DIV      = (mode != 0);
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
   endtask

   // Returns the number of edges from the start edge to the edge that samples RDY high.
   task automatic wait_rdy(input bit chk_div_op, output int edges);
      int  k;
      bit  seen;
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 60) begin
         if (chk_div_op && k < 32) check("div_run_opcode", 32'(alu_opcode), 32'd1);
         @(posedge clock);
         #1;
         k++;
         if (data_resultRDY) seen = 1'b1;
      end
      edges = k + 1;
   endtask

   task automatic do_op(input int mode, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      logic        ee;
      int          edges;
      ref_model(mode, a, b, er, ee);
      start_op(mode, a, b);
      check("busy_run", 32'(busy), 32'd1);
      check("result_hold", data_result, exp_hold);
      wait_rdy(mode == 1, edges);
      check("latency", 32'(edges), 32'd34);
      check("result", data_result, er);
      check("exception", 32'(data_exception), 32'(ee));
      check("busy_at_rdy", 32'(busy), 32'd0);
      check("alu_idle", alu_operandA | alu_operandB | 32'(alu_opcode) | 32'(alu_shamt), 32'd0);
      exp_hold = er;
      @(posedge clock);
      #1;
      check("rdy_one_cycle", 32'(data_resultRDY), 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 2000));
         5:       return -32'($urandom_range(1, 2000));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int rdy_seen;
      reset         = 1'b1;
      data_operandA = 32'd0;
      data_operandB = 32'd0;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_result", data_result, 32'd0);
      check("reset_exc", 32'(data_exception), 32'd0);
      check("reset_rdy", 32'(data_resultRDY), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_alu", alu_operandA | alu_operandB | 32'(alu_opcode), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      do_op(0, 32'd7, 32'hFFFF_FFFD);
      do_op(0, 32'h0001_0000, 32'h0001_0000);
      do_op(0, 32'h8000_0000, 32'd1);
      do_op(0, 32'h8000_0000, 32'h8000_0000);
      do_op(1, 32'hFFFF_FFF9, 32'd2);
      do_op(1, 32'd100, 32'd7);
      do_op(1, 32'd5, 32'd0);
      do_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(1, 32'h8000_0000, 32'd1);

      // Abort a multiply with a divide ten edges later.
      start_op(0, 32'd5, 32'd6);
      repeat (9) @(posedge clock);
      do_op(1, 32'd100, 32'd7);

      for (int i = 0; i < 40; i++) begin
         do_op(int'($urandom_range(0, 1)), pick(), pick());
      end

      // Reset in the middle of a multiply.
      start_op(0, 32'd1234, 32'd5678);
      repeat (15) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_rdy", 32'(data_resultRDY), 32'd0);
      check("midreset_result", data_result, 32'd0);
      @(negedge clock);
      reset    = 1'b0;
      exp_hold = 32'd0;
      rdy_seen = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) rdy_seen++;
      end
      check("aborted_no_rdy", 32'(rdy_seen), 32'd0);

      do_op(2, 32'd9, 32'hFFFF_FFFB);
      do_op(2, 32'hFFFF_FFF0, 32'd3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
